// File: rtl/mux_4_1_rr_sel.sv
// mux_4_1_rr_sel: round-robin grant/select generator feeding Sel1/Sel0 of a 4:1 mux.
// Optional BUSY watchdog with forced release is built when RR_SEL_TIMEOUT_EN is defined.
module mux_4_1_rr_sel #(
    parameter int HOLD_MIN = 1,
    parameter int TIMEOUT  = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] Req,
    input  logic       Done,
    output logic       Sel1,
    output logic       Sel0,
    output logic [3:0] Grant,
    output logic       Valid,
    output logic       Timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_MIN_C = 8'(HOLD_MIN);

    if ((HOLD_MIN < 1) || (HOLD_MIN > 255) || (TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_param_check
        $error("mux_4_1_rr_sel: HOLD_MIN or TIMEOUT outside legal range");
    end

    // First requester at or after ptr, wrapping mod 4; the i=0 candidate wins last.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] grant_q, grant_d;
    logic       valid_q, valid_d;
    logic       timeout_q, timeout_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [1:0] pick_s;
    logic       normal_rel_s;
    logic       force_rel_s;

`ifdef RR_SEL_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    logic [7:0] wd_q, wd_d;
`endif

    // Next-state and next-output logic for the IDLE/BUSY/RELEASE sequence.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        grant_d      = grant_q;
        valid_d      = valid_q;
        timeout_d    = 1'b0;
        ptr_d        = ptr_q;
        hold_d       = hold_q;
        pick_s       = rr_pick(Req, ptr_q);
        normal_rel_s = (Done && (hold_q >= HOLD_MIN_C)) || !Req[sel_q];
`ifdef RR_SEL_TIMEOUT_EN
        wd_d         = wd_q;
        force_rel_s  = (wd_q >= TIMEOUT_C);
`else
        force_rel_s  = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (Req != 4'b0000) begin
                    state_d = ST_BUSY;
                    sel_d   = pick_s;
                    grant_d = 4'b0001 << pick_s;
                    valid_d = 1'b1;
                    hold_d  = 8'd1;
`ifdef RR_SEL_TIMEOUT_EN
                    wd_d    = 8'd1;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (normal_rel_s || force_rel_s) begin
                    state_d   = ST_RELEASE;
                    grant_d   = 4'b0000;
                    valid_d   = 1'b0;
                    ptr_d     = sel_q + 2'd1;
                    // A normal release in the same cycle suppresses the timeout pulse.
                    timeout_d = force_rel_s && !normal_rel_s;
                end else begin
                    hold_d = (hold_q < HOLD_MIN_C) ? (hold_q + 8'd1) : hold_q;
`ifdef RR_SEL_TIMEOUT_EN
                    wd_d   = wd_q + 8'd1;
`endif
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; Rst overrides every other input.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= 2'b00;
            grant_q   <= 4'b0000;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= 2'b00;
            hold_q    <= 8'd0;
`ifdef RR_SEL_TIMEOUT_EN
            wd_q      <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
`ifdef RR_SEL_TIMEOUT_EN
            wd_q      <= wd_d;
`endif
        end
    end

    assign Sel1    = sel_q[1];
    assign Sel0    = sel_q[0];
    assign Grant   = grant_q;
    assign Valid   = valid_q;
    assign Timeout = timeout_q;

endmodule

// File: tb/tb_mux_4_1_rr_sel.sv
// Bench for mux_4_1_rr_sel: vector table, directed corner sequences and a random run,
// with two instances (HOLD_MIN=1/TIMEOUT=16 and HOLD_MIN=4/TIMEOUT=5) tracked by a reference model.
module tb_mux_4_1_rr_sel;

`ifdef RR_SEL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic       a_sel1, a_sel0, a_valid, a_to;
    logic [3:0] a_grant;
    logic       b_sel1, b_sel0, b_valid, b_to;
    logic [3:0] b_grant;

    int total = 0;
    int bad   = 0;

    mux_4_1_rr_sel #(.HOLD_MIN(1), .TIMEOUT(16)) dut_a (
        .Clk(clk), .Rst(rst), .Req(req), .Done(done),
        .Sel1(a_sel1), .Sel0(a_sel0), .Grant(a_grant), .Valid(a_valid), .Timeout(a_to)
    );

    mux_4_1_rr_sel #(.HOLD_MIN(4), .TIMEOUT(5)) dut_b (
        .Clk(clk), .Rst(rst), .Req(req), .Done(done),
        .Sel1(b_sel1), .Sel0(b_sel0), .Grant(b_grant), .Valid(b_valid), .Timeout(b_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner channel (-1 when none), release-cycle flag, next search start.
    int m_own[2];
    bit m_rel[2];
    int m_ptr[2];
    int m_sel[2];
    int m_hold[2];
    int m_wd[2];
    bit m_to[2];

    function automatic int hm_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int tov_of(input int i);
        return (i == 0) ? 16 : 5;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit normal;
            bit forced;
            if (rst) begin
                m_own[i] = -1; m_rel[i] = 1'b0; m_ptr[i] = 0; m_sel[i] = 0;
                m_hold[i] = 0; m_wd[i] = 0; m_to[i] = 1'b0;
            end else if (m_rel[i]) begin
                m_rel[i] = 1'b0;
                m_to[i]  = 1'b0;
            end else if (m_own[i] >= 0) begin
                normal = (done && (m_hold[i] >= hm_of(i))) || !req[m_own[i]];
                forced = TO_EN && (m_wd[i] >= tov_of(i));
                if (normal || forced) begin
                    m_rel[i] = 1'b1;
                    m_to[i]  = !normal;
                    m_ptr[i] = (m_own[i] + 1) % 4;
                    m_own[i] = -1;
                end else begin
                    if (m_hold[i] < hm_of(i)) m_hold[i] = m_hold[i] + 1;
                    m_wd[i] = m_wd[i] + 1;
                end
            end else if (req != 4'b0000) begin
                for (int k = 3; k >= 0; k--) begin
                    int c;
                    c = (m_ptr[i] + k) % 4;
                    if (req[c]) m_own[i] = c;
                end
                m_sel[i]  = m_own[i];
                m_hold[i] = 1;
                m_wd[i]   = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("a_valid",   32'(a_valid), 32'(m_own[0] >= 0));
        chk("a_grant",   32'(a_grant), (m_own[0] >= 0) ? (32'd1 << m_own[0]) : 32'd0);
        chk("a_sel",     32'({a_sel1, a_sel0}), 32'(m_sel[0]));
        chk("a_timeout", 32'(a_to), 32'(m_to[0]));
        chk("b_valid",   32'(b_valid), 32'(m_own[1] >= 0));
        chk("b_grant",   32'(b_grant), (m_own[1] >= 0) ? (32'd1 << m_own[1]) : 32'd0);
        chk("b_sel",     32'({b_sel1, b_sel0}), 32'(m_sel[1]));
        chk("b_timeout", 32'(b_to), 32'(m_to[1]));
    endtask

    task automatic cyc(input logic r, input logic [3:0] q, input logic d);
        rst  = r;
        req  = q;
        done = d;
        @(posedge clk);
        model_step();
        #1;
        check_model();
        @(negedge clk);
    endtask

    typedef struct {
        logic       r;
        logic [3:0] q;
        logic       d;
        logic [1:0] sel;
        logic [3:0] g;
        logic       v;
    } vec_t;

    vec_t tbl[31];

    initial begin
        logic [3:0] rq;
        logic       rr;
        logic       rd;

        rst = 1'b1; req = 4'b0000; done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_own[i] = -1; m_rel[i] = 1'b0; m_ptr[i] = 0; m_sel[i] = 0;
            m_hold[i] = 0; m_wd[i] = 0; m_to[i] = 1'b0;
        end

        // Expected outputs of the HOLD_MIN=1 instance after each edge.
        tbl[0]  = '{1'b1, 4'b1111, 1'b0, 2'b00, 4'b0000, 1'b0};
        tbl[1]  = '{1'b1, 4'b1111, 1'b0, 2'b00, 4'b0000, 1'b0};
        tbl[2]  = '{1'b0, 4'b1111, 1'b0, 2'b00, 4'b0001, 1'b1};
        tbl[3]  = '{1'b0, 4'b1111, 1'b1, 2'b00, 4'b0000, 1'b0};
        tbl[4]  = '{1'b0, 4'b1111, 1'b0, 2'b00, 4'b0000, 1'b0};
        tbl[5]  = '{1'b0, 4'b1111, 1'b0, 2'b01, 4'b0010, 1'b1};
        tbl[6]  = '{1'b0, 4'b1111, 1'b1, 2'b01, 4'b0000, 1'b0};
        tbl[7]  = '{1'b0, 4'b1111, 1'b0, 2'b01, 4'b0000, 1'b0};
        tbl[8]  = '{1'b0, 4'b1111, 1'b0, 2'b10, 4'b0100, 1'b1};
        tbl[9]  = '{1'b0, 4'b1111, 1'b1, 2'b10, 4'b0000, 1'b0};
        tbl[10] = '{1'b0, 4'b1111, 1'b0, 2'b10, 4'b0000, 1'b0};
        tbl[11] = '{1'b0, 4'b1111, 1'b0, 2'b11, 4'b1000, 1'b1};
        tbl[12] = '{1'b0, 4'b1111, 1'b1, 2'b11, 4'b0000, 1'b0};
        tbl[13] = '{1'b0, 4'b1111, 1'b0, 2'b11, 4'b0000, 1'b0};
        tbl[14] = '{1'b0, 4'b1111, 1'b0, 2'b00, 4'b0001, 1'b1};
        tbl[15] = '{1'b1, 4'b0100, 1'b0, 2'b00, 4'b0000, 1'b0};
        tbl[16] = '{1'b0, 4'b0100, 1'b0, 2'b10, 4'b0100, 1'b1};
        tbl[17] = '{1'b0, 4'b0100, 1'b1, 2'b10, 4'b0000, 1'b0};
        tbl[18] = '{1'b0, 4'b0000, 1'b0, 2'b10, 4'b0000, 1'b0};
        tbl[19] = '{1'b0, 4'b0000, 1'b0, 2'b10, 4'b0000, 1'b0};
        tbl[20] = '{1'b0, 4'b1000, 1'b0, 2'b11, 4'b1000, 1'b1};
        tbl[21] = '{1'b0, 4'b1000, 1'b0, 2'b11, 4'b1000, 1'b1};
        tbl[22] = '{1'b0, 4'b0000, 1'b0, 2'b11, 4'b0000, 1'b0};
        tbl[23] = '{1'b0, 4'b0000, 1'b0, 2'b11, 4'b0000, 1'b0};
        tbl[24] = '{1'b0, 4'b1111, 1'b0, 2'b00, 4'b0001, 1'b1};
        tbl[25] = '{1'b0, 4'b0000, 1'b1, 2'b00, 4'b0000, 1'b0};
        tbl[26] = '{1'b0, 4'b0000, 1'b0, 2'b00, 4'b0000, 1'b0};
        tbl[27] = '{1'b0, 4'b0010, 1'b0, 2'b01, 4'b0010, 1'b1};
        tbl[28] = '{1'b0, 4'b0010, 1'b1, 2'b01, 4'b0000, 1'b0};
        tbl[29] = '{1'b0, 4'b0010, 1'b0, 2'b01, 4'b0000, 1'b0};
        tbl[30] = '{1'b0, 4'b0010, 1'b0, 2'b01, 4'b0010, 1'b1};

        for (int i = 0; i < 31; i++) begin
            cyc(tbl[i].r, tbl[i].q, tbl[i].d);
            chk("tbl_sel",     32'({a_sel1, a_sel0}), 32'(tbl[i].sel));
            chk("tbl_grant",   32'(a_grant), 32'(tbl[i].g));
            chk("tbl_valid",   32'(a_valid), 32'(tbl[i].v));
            chk("tbl_timeout", 32'(a_to), 32'd0);
        end

        // HOLD_MIN=4: early Done ignored and not remembered; Done on BUSY cycle 4 releases.
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0001, 1'b0);
        chk("hm4_grant", 32'(b_grant), 32'h1);
        cyc(1'b0, 4'b0001, 1'b0);
        chk("hm4_c1", 32'(b_valid), 32'd1);
        cyc(1'b0, 4'b0001, 1'b1);
        chk("hm4_early_done", 32'(b_valid), 32'd1);
        cyc(1'b0, 4'b0001, 1'b0);
        chk("hm4_c3", 32'(b_valid), 32'd1);
        cyc(1'b0, 4'b0001, 1'b1);
        chk("hm4_release", 32'(b_valid), 32'd0);
        chk("hm4_rel_grant", 32'(b_grant), 32'd0);

`ifdef RR_SEL_TIMEOUT_EN
        // TIMEOUT=5: forced release after the 5th BUSY cycle, then search resumes at channel 2.
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0010, 1'b0);
        chk("to_grant", 32'(b_grant), 32'h2);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b0, 4'b0010, 1'b0);
            chk("to_busy_valid", 32'(b_valid), 32'd1);
            chk("to_busy_pulse", 32'(b_to), 32'd0);
        end
        cyc(1'b0, 4'b0010, 1'b0);
        chk("to_pulse", 32'(b_to), 32'd1);
        chk("to_valid", 32'(b_valid), 32'd0);
        cyc(1'b0, 4'b0011, 1'b0);
        chk("to_pulse_end", 32'(b_to), 32'd0);
        cyc(1'b0, 4'b0011, 1'b0);
        chk("to_ptr2", 32'(b_grant), 32'h1);
        cyc(1'b0, 4'b0011, 1'b0);
        cyc(1'b0, 4'b0011, 1'b0);
        cyc(1'b1, 4'b0011, 1'b0);
        chk("to_rst_valid", 32'(b_valid), 32'd0);
        chk("to_rst_sel", 32'({b_sel1, b_sel0}), 32'd0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 4'b0011, 1'b0);
            chk("to_rst_pulse", 32'(b_to), 32'd0);
        end
`else
        // Without the watchdog a grant is held indefinitely.
        cyc(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 4'b0010, 1'b0);
        end
        chk("nowd_valid", 32'(b_valid), 32'd1);
        chk("nowd_pulse", 32'(b_to), 32'd0);
`endif

        // Random traffic against the model; requests change occasionally so grants persist.
        cyc(1'b1, 4'b0000, 1'b0);
        rq = 4'b1111;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 79) == 0);
            rd = ($urandom_range(0, 3) == 0);
            cyc(rr, rq, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_4_1_rr_sel.md
# mux_4_1_rr_sel

Round-robin select generator for the four-input dataflow mux. It arbitrates four request lines and drives `Sel1`/`Sel0` directly into the mux select pins. It holds each grant until the consumer signals completion, then advances fairly to the next requester. It is the stage directly upstream of the 4:1 mux and turns per-channel requests into a stable, glitch-free 2-bit select.

## Interface
- `HOLD_MIN`, default 1: minimum cycles a grant is held before `Done` is honoured; legal range 1..255.
- `TIMEOUT`, default 16: maximum BUSY cycles before a forced release; used only with `RR_SEL_TIMEOUT_EN`; legal range 2..255.

- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `Req`  in  4  per-channel request; bit n corresponds to mux input `In`n.
- `Done` in  1  consumer finished with the current channel; sampled only in BUSY.
- `Sel1` out 1  select MSB to the mux.
- `Sel0` out 1  select LSB to the mux.
- `Grant` out 4 one-hot grant, equal to decode({`Sel1`,`Sel0`}) while `Valid`=1; 0000 otherwise.
- `Valid` out 1 the current select is granted and stable.
- `Timeout` out 1 one-cycle pulse on a forced release; constant 0 without the macro.

## Operation
- State machine: IDLE → BUSY → RELEASE → IDLE. Encoding is free.
- **IDLE**:
  - If `Req`≠0, choose the first set bit searching Ptr, Ptr+1, … mod 4.
  - Register {`Sel1`,`Sel0`} = chosen index, set `Grant`, set `Valid`=1, clear HoldCnt to 1, go to BUSY.
  - If `Req`=0, stay in IDLE with the outputs held.
- **BUSY**:
  - HoldCnt (8 bits) increments each cycle and saturates at `HOLD_MIN`.
  - Release when either:
    - `Done`=1 and HoldCnt≥`HOLD_MIN`, or
    - the granted channel's `Req` bit is 0, regardless of HoldCnt.
  - `Done` seen before HoldCnt reaches `HOLD_MIN` is ignored and not remembered.
- **RELEASE** (exactly one cycle):
  - `Valid`=0 and `Grant`=0000.
  - `Sel1`/`Sel0` keep their last value, so the mux sees no select glitch.
  - Ptr = granted index + 1 mod 4, then go to IDLE.
- Requests from other channels during BUSY never preempt the grant.
- `Sel1`/`Sel0` change only on the IDLE→BUSY edge.

## Timing
- Reset values: `Sel1`=0, `Sel0`=0, `Grant`=0000, `Valid`=0, `Timeout`=0, Ptr=0, HoldCnt=0, state IDLE.
- Grant latency: `Req` sampled high in IDLE at edge k gives `Valid`=1 after edge k.
- Release latency: a release condition sampled at edge k gives `Valid`=0 after edge k.
- Minimum gap between consecutive grants: 2 cycles with `Valid`=0 (RELEASE, then IDLE).
- `Done` and a `Req` drop in the same cycle count as one normal release.
- `Rst` asserted in any state returns everything to the reset values on that edge. `Rst` overrides all other inputs.
- Single requester: re-granted to the same channel after the 2-cycle gap.

## Configuration
- `RR_SEL_TIMEOUT_EN` defined:
  - An 8-bit watchdog counts BUSY cycles starting at 1.
  - When it reaches `TIMEOUT` with no normal release, the block forces a release: state goes to RELEASE, `Timeout`=1 for that RELEASE cycle, and Ptr advances normally.
  - A normal release in the same cycle takes priority, so `Timeout` stays 0.
- `RR_SEL_TIMEOUT_EN` undefined: no watchdog logic, `Timeout` tied 0, and BUSY can last indefinitely.

## Test plan
- Reset: drive `Rst`=1 for 2 cycles with `Req`=1111 → all outputs at reset values. On the first edge after release, `Sel`=00, `Grant`=0001, `Valid`=1.
- Single request: `Req`=0100 from IDLE → `Valid`=1 next cycle, {`Sel1`,`Sel0`}=10, `Grant`=0100. Pulse `Done` → `Valid`=0 for 2 cycles, `Sel` stays 10 throughout.
- Fairness: `Req`=1111 held, `Done` pulsed once per grant → grant order 0,1,2,3,0. Check that each select value is stable while `Valid`=1.
- `HOLD_MIN`=4: `Done`=1 on BUSY cycle 2 only → ignored. `Done`=1 on cycle 4 → `Valid` falls after that edge.
- Request drop: grant channel 3 with `Req`=1000, then drop to 0000 mid-BUSY → release next edge, and the next grant search starts at channel 0.
- Macro on, `TIMEOUT`=5: grant channel 1 with `Done` held 0 → `Timeout` pulses 1 cycle after the 5th BUSY cycle and `Ptr` becomes 2. With `Rst` asserted mid-BUSY instead → immediate return to reset values, no `Timeout`.
